// File: rtl/w_load_pkg.sv
// Shared types and sizing for the weight-load scheduler.
package w_load_pkg;

    localparam int unsigned SYS_ROW    = 16;
    localparam int unsigned SYS_COL    = 16;
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ACCUM_SIZE = 1024;

    // Number of whole tiles one column bank of weight memory can hold.
    function automatic int unsigned calc_max_tiles(int unsigned accum, int unsigned cols,
                                                   int unsigned rows);
        return accum / cols / rows;
    endfunction

    // Tile-count width: enough to hold MAX_TILES itself plus out-of-range requests.
    function automatic int unsigned calc_tile_w(int unsigned max_tiles);
        return $clog2(max_tiles) + 1;
    endfunction

    localparam int unsigned MAX_TILES = calc_max_tiles(ACCUM_SIZE, SYS_COL, SYS_ROW);
    localparam int unsigned TILE_W    = calc_tile_w(MAX_TILES);
    localparam int unsigned ROW_W     = $clog2(SYS_ROW);
    localparam int unsigned ACC_W     = TILE_W + ROW_W;

    typedef logic [0:SYS_COL-1][DATA_WIDTH-1:0] row_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        STREAM,
        SINK,
        DONE
    } w_load_state_e;

endpackage

// File: rtl/w_load_sched_if.sv
// Command, row-stream and write-controller signals of the weight-load scheduler.
interface w_load_sched_if;
    import w_load_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [TILE_W-1:0] cmd_num_tiles;
    logic              in_valid;
    logic              in_ready;
    row_t              in_data;
    logic              w_en;
    row_t              w_data;
    logic              busy;
    logic              done;
    logic              err_underrun;
    logic              err_cmd;

    modport master (
        output cmd_valid, cmd_num_tiles, in_valid, in_data,
        input  cmd_ready, in_ready, w_en, w_data, busy, done, err_underrun, err_cmd
    );

    modport slave (
        input  cmd_valid, cmd_num_tiles, in_valid, in_data,
        output cmd_ready, in_ready, w_en, w_data, busy, done, err_underrun, err_cmd
    );

endinterface

// File: rtl/w_tile_buf.sv
// Two-bank ping-pong tile store: one bank fills while the other is read out.
module w_tile_buf
    import w_load_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  row_t             wr_data,
    input  logic             rd_adv,
    input  logic             swap,
    output row_t             rd_data,
    output logic             wr_full,
    output logic             fill_done,
    output logic [ROW_W-1:0] wr_row,
    output logic [ROW_W-1:0] rd_row
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SYS_ROW - 1);

    row_t       mem [2][SYS_ROW];
    logic       wr_bank;
    logic       rd_bank;
    logic [1:0] full;

    // Row storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_row] <= wr_data;
        end
    end

    // Pointers and full flags; the write bank advances on its own after each completed bank.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_bank <= 1'b0;
            wr_row  <= '0;
            rd_bank <= 1'b0;
            rd_row  <= '0;
            full    <= '0;
        end else begin
            if (wr_en) begin
                wr_row <= wr_row + ROW_W'(1);
                if (wr_row == ROW_LAST) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (rd_adv) begin
                rd_row <= rd_row + ROW_W'(1);
            end
            if (swap) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

    assign rd_data   = mem[rd_bank][rd_row];
    assign wr_full   = full[wr_bank];
    assign fill_done = full[~rd_bank];

endmodule

// File: rtl/w_load_sched.sv
// Weight-load scheduler: buffers weight tiles and streams them gap-free to the
// weight-memory write controller. Optional W_LOAD_STATS_EN adds tile/underrun counters.
module w_load_sched
    import w_load_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    w_load_sched_if.slave bus
`ifdef W_LOAD_STATS_EN
    ,
    output logic [31:0]   stat_tiles,
    output logic [15:0]   stat_underruns
`endif
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SYS_ROW - 1);

    w_load_state_e     state;
    logic [TILE_W-1:0] num_tiles;
    logic [TILE_W-1:0] tile_cnt;
    logic [ACC_W-1:0]  acc_cnt;
    logic [ACC_W-1:0]  total_rows;
    logic              in_ready_c;
    logic              accept;
    logic              rows_left;
    logic              last_row;
    logic              last_tile;
    logic              fill_ok;
    logic              underrun_c;
    logic              legal;
    logic              buf_wr;
    logic              rd_adv;
    logic              swap;
    logic              wr_full;
    logic              fill_done;
    logic [ROW_W-1:0]  wr_row;
    logic [ROW_W-1:0]  rd_row;
    row_t              rd_data;

    assign total_rows = {num_tiles, {ROW_W{1'b0}}};
    assign rows_left  = acc_cnt < total_rows;
    assign legal      = (bus.cmd_num_tiles != '0) && (bus.cmd_num_tiles <= TILE_W'(MAX_TILES));

    // Row-stream ready, decoded from state and buffer flops only.
    always_comb begin
        in_ready_c = 1'b0;
        case (state)
            FILL:    in_ready_c = 1'b1;
            STREAM:  in_ready_c = !wr_full && rows_left;
            SINK:    in_ready_c = rows_left;
            default: in_ready_c = 1'b0;
        endcase
    end

    assign bus.in_ready = in_ready_c;
    assign accept       = bus.in_valid && in_ready_c;
    assign last_row     = rd_row == ROW_LAST;
    assign last_tile    = (tile_cnt + TILE_W'(1)) == num_tiles;
    // The next tile counts as ready if its final row lands in this same cycle.
    assign fill_ok      = fill_done || (accept && (wr_row == ROW_LAST));
    assign underrun_c   = (state == STREAM) && last_row && !last_tile && !fill_ok;
    assign buf_wr       = accept && (state != SINK);
    assign rd_adv       = state == STREAM;
    assign swap         = (state == STREAM) && last_row && !last_tile && fill_ok;

    w_tile_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (bus.cmd_valid && bus.cmd_ready),
        .wr_en     (buf_wr),
        .wr_data   (bus.in_data),
        .rd_adv    (rd_adv),
        .swap      (swap),
        .rd_data   (rd_data),
        .wr_full   (wr_full),
        .fill_done (fill_done),
        .wr_row    (wr_row),
        .rd_row    (rd_row)
    );

    // Outside a burst the write data is held at zero rather than exposing stale buffer contents.
    assign bus.w_data = bus.w_en ? rd_data : '0;

    // Command sequencing FSM with registered handshake, enable and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            num_tiles        <= '0;
            tile_cnt         <= '0;
            acc_cnt          <= '0;
            bus.cmd_ready    <= 1'b1;
            bus.w_en         <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.err_underrun <= 1'b0;
            bus.err_cmd      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (accept) begin
                acc_cnt <= acc_cnt + ACC_W'(1);
            end
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.err_underrun <= 1'b0;
                        bus.err_cmd      <= 1'b0;
                        num_tiles        <= bus.cmd_num_tiles;
                        tile_cnt         <= '0;
                        acc_cnt          <= '0;
                        bus.cmd_ready    <= 1'b0;
                        bus.busy         <= 1'b1;
                        if (legal) begin
                            state <= FILL;
                        end else begin
                            bus.err_cmd <= 1'b1;
                            bus.done    <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                FILL: begin
                    if (accept && (wr_row == ROW_LAST)) begin
                        bus.w_en <= 1'b1;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (last_row) begin
                        tile_cnt <= tile_cnt + TILE_W'(1);
                        if (last_tile) begin
                            bus.w_en <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else if (!fill_ok) begin
                            bus.w_en         <= 1'b0;
                            bus.err_underrun <= 1'b1;
                            state            <= SINK;
                        end
                    end
                end
                SINK: begin
                    if (accept && ((acc_cnt + ACC_W'(1)) == total_rows)) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.busy      <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    bus.w_en <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef W_LOAD_STATS_EN
    // Lifetime counters of emitted tiles and underruns; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_tiles     <= '0;
            stat_underruns <= '0;
        end else begin
            if ((state == STREAM) && last_row) begin
                stat_tiles <= stat_tiles + 32'(1);
            end
            if (underrun_c && (stat_underruns != '1)) begin
                stat_underruns <= stat_underruns + 16'(1);
            end
        end
    end
`else
    logic unused_underrun;
    assign unused_underrun = underrun_c;
`endif

endmodule

// File: tb/tb_w_load_sched.sv
// Directed bench for w_load_sched: streaming, underrun, illegal commands, back-to-back and reset.
module tb_w_load_sched;
    import w_load_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   cmd_cyc;
    logic [3:0] seed;

    int n_acc, n_emit, we_first, we_last, we_runs, done_cnt, done_cyc, acc15_cyc, ur_cyc;

    w_load_sched_if bus ();

`ifdef W_LOAD_STATS_EN
    logic [31:0] stat_tiles;
    logic [15:0] stat_underruns;
`endif

    w_load_sched dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus)
`ifdef W_LOAD_STATS_EN
        ,
        .stat_tiles     (stat_tiles),
        .stat_underruns (stat_underruns)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic row_t mk_row(input logic [3:0] s, input int k);
        row_t r;
        for (int j = 0; j < int'(SYS_COL); j++) begin
            r[j] = {s, 6'(k), 6'(j)};
        end
        return r;
    endfunction

    task automatic issue_cmd(input logic [TILE_W-1:0] n);
        bus.cmd_valid     = 1'b1;
        bus.cmd_num_tiles = n;
        check_val("cmd_ready_idle", 256'(bus.cmd_ready), 256'(1));
        cmd_cyc = cyc;
        step();
        bus.cmd_valid = 1'b0;
        check_val("busy_after_cmd", 256'(bus.busy), 256'(1));
        check_val("cmd_ready_busy", 256'(bus.cmd_ready), 256'(0));
    endtask

    // Feeds rows (optionally pausing after row gap_row) and records the w_en burst.
    task automatic run_load(input int gap_row, input int gap_len, input int budget);
        int   gap_left;
        logic prev_we;
        n_acc = 0; n_emit = 0; we_first = -1; we_last = -1; we_runs = 0;
        done_cnt = 0; done_cyc = -1; acc15_cyc = -1; ur_cyc = -1;
        gap_left = 0; prev_we = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.w_en) begin
                if (!prev_we) we_runs++;
                if (we_first < 0) we_first = cyc;
                we_last = cyc;
                check_val("w_data", 256'(bus.w_data), 256'(mk_row(seed, n_emit)));
                n_emit++;
            end
            prev_we = bus.w_en;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.err_underrun && ur_cyc < 0) ur_cyc = cyc;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            if (gap_left > 0) begin
                bus.in_valid = 1'b0;
                gap_left--;
            end else begin
                bus.in_valid = 1'b1;
            end
            bus.in_data = mk_row(seed, n_acc);
            if (bus.in_valid && bus.in_ready) begin
                if (n_acc == 15) acc15_cyc = cyc;
                if (n_acc == gap_row) gap_left = gap_len;
                n_acc++;
            end
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int   len1, len2, gap, cur, zeros, runs, n_cmd, we_seen;
        logic prev_we;

        rst               = 1'b1;
        bus.cmd_valid     = 1'b0;
        bus.cmd_num_tiles = '0;
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        seed              = 4'd0;
        step();
        step();
        check_val("rst_w_en",      256'(bus.w_en),         256'(0));
        check_val("rst_w_data",    256'(bus.w_data),       256'(0));
        check_val("rst_busy",      256'(bus.busy),         256'(0));
        check_val("rst_done",      256'(bus.done),         256'(0));
        check_val("rst_err_ur",    256'(bus.err_underrun), 256'(0));
        check_val("rst_err_cmd",   256'(bus.err_cmd),      256'(0));
        check_val("rst_in_ready",  256'(bus.in_ready),     256'(0));
        check_val("rst_cmd_ready", 256'(bus.cmd_ready),    256'(1));
        rst = 1'b0;
        step();

        // Two tiles, rows supplied every cycle.
        seed = 4'd1;
        issue_cmd(3'd2);
        check_val("t1_in_ready", 256'(bus.in_ready), 256'(1));
        run_load(-1, 0, 300);
        check_val("t1_we_first", 256'(we_first), 256'(cmd_cyc + 17));
        check_val("t1_we_after15", 256'(we_first), 256'(acc15_cyc + 1));
        check_val("t1_we_last",  256'(we_last),  256'(cmd_cyc + 48));
        check_val("t1_emit",     256'(n_emit),   256'(32));
        check_val("t1_runs",     256'(we_runs),  256'(1));
        check_val("t1_acc",      256'(n_acc),    256'(32));
        check_val("t1_done_cnt", 256'(done_cnt), 256'(1));
        check_val("t1_done_cyc", 256'(done_cyc), 256'(cmd_cyc + 49));
        check_val("t1_err_ur",   256'(bus.err_underrun), 256'(0));
        check_val("t1_err_cmd",  256'(bus.err_cmd),      256'(0));

        // Four tiles with a 20-cycle stall after row 20.
        seed = 4'd2;
        issue_cmd(3'd4);
        run_load(20, 20, 400);
        check_val("t2_we_first", 256'(we_first), 256'(cmd_cyc + 17));
        check_val("t2_we_last",  256'(we_last),  256'(cmd_cyc + 32));
        check_val("t2_emit",     256'(n_emit),   256'(16));
        check_val("t2_runs",     256'(we_runs),  256'(1));
        check_val("t2_ur_cyc",   256'(ur_cyc),   256'(cmd_cyc + 33));
        check_val("t2_acc",      256'(n_acc),    256'(64));
        check_val("t2_done_cnt", 256'(done_cnt), 256'(1));
        check_val("t2_done_cyc", 256'(done_cyc), 256'(cmd_cyc + 85));
        check_val("t2_err_ur",   256'(bus.err_underrun), 256'(1));
`ifdef W_LOAD_STATS_EN
        check_val("stat_tiles",     256'(stat_tiles),     256'(3));
        check_val("stat_underruns", 256'(stat_underruns), 256'(1));
`endif

        // Illegal counts: zero and above MAX_TILES.
        for (int k = 0; k < 2; k++) begin
            issue_cmd((k == 0) ? 3'd0 : 3'd5);
            check_val("t3_done",     256'(bus.done),     256'(1));
            check_val("t3_err_cmd",  256'(bus.err_cmd),  256'(1));
            check_val("t3_w_en",     256'(bus.w_en),     256'(0));
            check_val("t3_in_ready", 256'(bus.in_ready), 256'(0));
            step();
            check_val("t3_done_off", 256'(bus.done),      256'(0));
            check_val("t3_w_en2",    256'(bus.w_en),      256'(0));
            check_val("t3_idle",     256'(bus.cmd_ready), 256'(1));
            check_val("t3_err_hold", 256'(bus.err_cmd),   256'(1));
        end
        seed = 4'd3;
        issue_cmd(3'd1);
        check_val("t3_err_clr", 256'(bus.err_cmd), 256'(0));
        run_load(-1, 0, 200);
        check_val("t3_emit",     256'(n_emit),   256'(16));
        check_val("t3_done_cyc", 256'(done_cyc), 256'(cmd_cyc + 33));

        // Back-to-back single-tile commands with cmd_valid held.
        seed = 4'd4;
        bus.cmd_valid = 1'b1;
        bus.cmd_num_tiles = 3'd1;
        len1 = 0; len2 = 0; gap = 0; cur = 0; zeros = 0; runs = 0; n_cmd = 0;
        done_cnt = 0; prev_we = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.w_en) begin
                if (!prev_we) begin
                    runs++;
                    if (runs == 2) gap = zeros;
                    cur = 0;
                end
                cur++;
            end else begin
                if (prev_we) begin
                    if (runs == 1) len1 = cur;
                    else if (runs == 2) len2 = cur;
                    zeros = 1;
                end else begin
                    zeros++;
                end
            end
            prev_we = bus.w_en;
            if (bus.done) done_cnt++;
            if (done_cnt == 2) break;
            if (bus.cmd_valid && bus.cmd_ready) n_cmd++;
            bus.in_valid = 1'b1;
            bus.in_data  = mk_row(seed, 0);
            step();
            if (n_cmd == 2) bus.cmd_valid = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.cmd_valid = 1'b0;
        step();
        check_val("t4_runs",  256'(runs),     256'(2));
        check_val("t4_len1",  256'(len1),     256'(16));
        check_val("t4_len2",  256'(len2),     256'(16));
        check_val("t4_gap",   256'(gap),      256'(18));
        check_val("t4_cmds",  256'(n_cmd),    256'(2));
        check_val("t4_dones", 256'(done_cnt), 256'(2));

        // Reset in the middle of a three-tile burst.
        seed = 4'd5;
        issue_cmd(3'd3);
        we_seen = 0;
        for (int i = 0; i < 100; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mk_row(seed, i);
            if (bus.w_en) we_seen++;
            if (we_seen == 8) begin
                rst = 1'b1;
                break;
            end
            step();
        end
        check_val("t5_we8", 256'(we_seen), 256'(8));
        step();
        check_val("t5_w_en",      256'(bus.w_en),      256'(0));
        check_val("t5_busy",      256'(bus.busy),      256'(0));
        check_val("t5_cmd_ready", 256'(bus.cmd_ready), 256'(1));
        check_val("t5_in_ready",  256'(bus.in_ready),  256'(0));
        check_val("t5_done",      256'(bus.done),      256'(0));
`ifdef W_LOAD_STATS_EN
        check_val("t5_stat_clr",  256'(stat_tiles),    256'(0));
`endif
        rst = 1'b0;
        bus.in_valid = 1'b0;
        step();
        seed = 4'd6;
        issue_cmd(3'd1);
        run_load(-1, 0, 200);
        check_val("t5_we_first", 256'(we_first), 256'(cmd_cyc + 17));
        check_val("t5_emit",     256'(n_emit),   256'(16));
        check_val("t5_runs",     256'(we_runs),  256'(1));
        check_val("t5_acc",      256'(n_acc),    256'(16));
        check_val("t5_done_cyc", 256'(done_cyc), 256'(cmd_cyc + 33));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
